hamming_secded_codec: RTL
=========================

HAMMING_SECDED_CODEC -- requirements
Module: hamming_secded_codec

Interface
REQ-001 Parameter DATA_W, 8, data payload width; SHALL be legal for 4..64.
REQ-002 Parameter CNT_W, 16, width of each error counter.
REQ-003 Derived PAR_W SHALL be the smallest r with 2^r >= DATA_W+r+1; CODE_W SHALL be DATA_W+PAR_W+1 (DATA_W=8 gives PAR_W=4, CODE_W=13).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  block accepts beat this cycle.
REQ-008 in_op  in  1  0 = encode, 1 = decode.
REQ-009 in_word  in  CODE_W  encode: data in bits [DATA_W-1:0], upper bits ignored; decode: received codeword.
REQ-010 out_valid  in  1  output beat present (direction: out).
REQ-011 out_ready  in  1  downstream accepts beat.
REQ-012 out_op  out  1  in_op of this beat.
REQ-013 out_code  out  CODE_W  encode: generated codeword; decode: corrected codeword.
REQ-014 out_data  out  DATA_W  encode: input data; decode: extracted (corrected) data.
REQ-015 out_sec  out  1  decode: single error corrected/detected.
REQ-016 out_ded  out  1  decode: uncorrectable error.
REQ-017 out_syndrome  out  PAR_W  decode: raw syndrome; 0 for encode.
REQ-018 clr_cnt  in  1  synchronous counter clear.
REQ-019 sec_cnt, ded_cnt  out  CNT_W each  saturating counts of delivered out_sec / out_ded beats.

Function
REQ-020 Codeword bit i SHALL be Hamming position i; parity bits at positions 1,2,4,8,...; data bits d0..d(DATA_W-1) fill remaining positions 3,5,6,7,9,... ascending; bit 0 SHALL be overall parity making total XOR of all CODE_W bits zero.
REQ-021 Parity bit at position 2^k SHALL equal XOR of all other positions whose index has bit k set.
REQ-022 Decode syndrome SHALL be XOR of indices of all set bits in positions 1..CODE_W-1; overall check = XOR of all CODE_W bits.
REQ-023 Decode classes: syn=0, check=0 -> no error; syn!=0, check=1, syn<CODE_W -> flip bit syn, out_sec=1; syn=0, check=1 -> flip bit 0, out_sec=1, data unchanged; syn!=0, check=0 -> out_ded=1; syn>=CODE_W -> out_ded=1.
REQ-024 On out_ded, out_code/out_data SHALL carry the uncorrected received word/data; out_sec and out_ded SHALL never both be 1; encode beats SHALL drive both 0.
REQ-025 Datapath SHALL be a two-stage pipeline (stage 1: syndrome/parity registered; stage 2: correction/extraction registered); latency input handshake to out_valid = 2 cycles without backpressure; throughput 1 beat/cycle.
REQ-026 Stage 2 SHALL advance when !s2_valid or out_ready; stage 1 when !s1_valid or stage 2 advances; in_ready = !s1_valid or stage 1 advances (no combinational in_valid->in_ready path).
REQ-027 Beats SHALL emerge in acceptance order with no loss or duplication; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 sec_cnt/ded_cnt SHALL increment only on out_valid&&out_ready with the corresponding flag, saturating at all-ones.
REQ-029 clr_cnt=1 SHALL zero both counters next edge, overriding a same-cycle increment; pipeline unaffected.

Reset
REQ-030 rst_n=0 at a clock edge SHALL clear s1_valid, s2_valid, out_valid, sec_cnt, ded_cnt; in_ready SHALL read 1 the cycle after reset release.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; datapath registers need not be reset.

Verification (DATA_W=8)
REQ-032 Encode 8'hA5, out_ready=1 -> 2 cycles later out_code=13'h144E, out_data=8'hA5, out_sec=0, out_ded=0.
REQ-033 Decode 13'h144E -> out_data=8'hA5, syndrome 0, flags 0; decode 13'h140E -> out_code=13'h144E, out_data=8'hA5, syndrome 6, out_sec=1, sec_cnt+1.
REQ-034 Decode 13'h144F -> out_sec=1, syndrome 0, out_code=13'h144E; decode 13'h1406 -> out_ded=1, syndrome 5, out_data=8'hA5 uncorrected, ded_cnt+1.
REQ-035 Stream 4 beats back-to-back with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, outputs held stable, all 4 delivered in order once out_ready=1.
REQ-036 Preload ded_cnt near max (CNT_W=2 build): 4 ded beats -> ded_cnt sticks at 3; clr_cnt with simultaneous ded beat -> 0; rst_n low with 2 beats in flight -> out_valid=0 next cycle, no beats delivered.

Source files
------------

// File: rtl/hamming_secded_codec.sv
`default_nettype none
// ============================================================================
// hamming_secded_codec : two-stage pipelined Hamming SECDED encoder/decoder
// Rev 1.0
// ============================================================================
module hamming_secded_codec #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 :
                           (DATA_W <= 57) ? 6 : 7,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_op,
    output logic [CODE_W-1:0] out_code,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    // Data bits occupy every non-power-of-two position above 0, lowest first.
    function automatic logic [CODE_W-1:0] f_scatter(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic [DATA_W-1:0] sh;
        c  = '0;
        sh = d;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = sh[0];
                sh   = sh >> 1;
            end
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] f_gather(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int p = CODE_W - 1; p >= 1; p--) begin
            if ((p & (p - 1)) != 0) begin
                d = {d[DATA_W-2:0], c[p]};
            end
        end
        return d;
    endfunction

    function automatic logic [PAR_W-1:0] f_syndrome(input logic [CODE_W-1:0] w);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (w[p]) begin
                s = s ^ PAR_W'(p);
            end
        end
        return s;
    endfunction

    logic              s1_valid_q, s2_valid_q;
    logic              s1_op_q, s2_op_q;
    logic [CODE_W-1:0] s1_word_q, s2_code_q;
    logic [PAR_W-1:0]  s1_syn_q, s2_syn_q;
    logic              s1_chk_q;
    logic [DATA_W-1:0] s2_data_q;
    logic              s2_sec_q, s2_ded_q;
    logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;

    logic              w_s1_adv, w_s2_adv, w_fire;
    logic [CODE_W-1:0] w_enc_code;
    logic [PAR_W-1:0]  w_enc_syn;
    logic              w_bad_pos, w_sec_d, w_ded_d;
    logic [CODE_W-1:0] w_code_d;

    assign w_s2_adv = !s2_valid_q || out_ready;
    assign w_s1_adv = !s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_fire   = s2_valid_q && out_ready;

    // With parity slots still zero, the syndrome of the data-only word is the parity vector.
    always_comb begin
        w_enc_code = f_scatter(in_word[DATA_W-1:0]);
        w_enc_syn  = f_syndrome(w_enc_code);
        for (int k = 0; k < PAR_W; k++) begin
            w_enc_code[1 << k] = w_enc_syn[k];
        end
        w_enc_code[0] = ^w_enc_code[CODE_W-1:1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (w_s1_adv) begin
            s1_valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            s1_op_q   <= in_op;
            s1_word_q <= in_op ? in_word : w_enc_code;
            s1_syn_q  <= in_op ? f_syndrome(in_word) : '0;
            s1_chk_q  <= in_op & (^in_word);
        end
    end

    // A zero syndrome with odd overall parity points at bit 0, so one shift covers both cases.
    always_comb begin
        w_bad_pos = 32'(s1_syn_q) >= CODE_W;
        w_sec_d   = s1_op_q && s1_chk_q && !w_bad_pos;
        w_ded_d   = s1_op_q && (s1_syn_q != '0) && (!s1_chk_q || w_bad_pos);
        w_code_d  = s1_word_q;
        if (w_sec_d) begin
            w_code_d = s1_word_q ^ (CODE_W'(1) << s1_syn_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
        end else if (w_s2_adv) begin
            s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s2_adv && s1_valid_q) begin
            s2_op_q   <= s1_op_q;
            s2_code_q <= w_code_d;
            s2_data_q <= f_gather(w_code_d);
            s2_sec_q  <= w_sec_d;
            s2_ded_q  <= w_ded_d;
            s2_syn_q  <= s1_syn_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            if (w_fire && s2_sec_q && !(&sec_cnt_q)) begin
                sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            end
            if (w_fire && s2_ded_q && !(&ded_cnt_q)) begin
                ded_cnt_q <= ded_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_op       = s2_op_q;
    assign out_code     = s2_code_q;
    assign out_data     = s2_data_q;
    assign out_sec      = s2_sec_q;
    assign out_ded      = s2_ded_q;
    assign out_syndrome = s2_syn_q;
    assign sec_cnt      = sec_cnt_q;
    assign ded_cnt      = ded_cnt_q;

endmodule
`default_nettype wire
